ahb_test_ctrl: RTL and testbench
================================

// Module: ahb_test_ctrl
// PURPOSE
//  AHB-Lite slave replacing ad-hoc testbench exit/cycle-limit logic with a synthesizable test controller.
//  Firmware on each of NUM_CH channels (harts/tests) writes an exit code; block counts cycles, enforces a
//  programmable watchdog limit and drives sticky pass/fail/timeout outputs. Sits on the AHB bus beside memory in top.
// PARAMETERS
//  NUM_CH        2           number of independent exit channels (1..8)
//  CNT_WIDTH     32          cycle counter / MAXCYCLE width (<=32)
//  DEF_MAXCYCLE  10_000_000  MAXCYCLE reset value; 0 = watchdog never fires
//  ADDR_LSBS     6           HADDR bits decoded (register window 2**ADDR_LSBS bytes)
// PORTS
//  HCLK            in   1          bus clock
//  HRESET          in   1          synchronous, active-high reset
//  HSEL            in   1          slave select
//  HADDR           in   32         byte address (only [ADDR_LSBS-1:2] decoded)
//  HTRANS          in   2          transfer type; NONSEQ/SEQ start a transfer
//  HWRITE          in   1          1 = write
//  HWDATA          in   32         write data (data phase)
//  HREADY          in   1          bus ready
//  HRDATA          out  32         read data
//  HREADYOUT       out  1          always 1 (zero wait)
//  HRESP           out  1          always 0 (OKAY)
//  tests_passed_o  out  1          all channels exited with code 0
//  tests_failed_o  out  1          any channel exited with nonzero code
//  timeout_o       out  1          watchdog expired before completion
//  exit_valid_o    out  1          1 once any terminal state is reached
//  exit_value_o    out  32         first nonzero exit code; 0 on pass; 32'hDEAD_0000|ch_mask on timeout
// BEHAVIOUR
//  Reset: all outputs 0 (HREADYOUT=1), cycle_cnt=0, MAXCYCLE=DEF_MAXCYCLE, CTRL.wd_en=1, state RUN, exit regs clear.
//  AHB: address phase accepted when HSEL&HTRANS[1]&HREADY; addr/write latched; write uses HWDATA next cycle;
//   read data driven on HRDATA in data phase (registered mux). Unmapped: read 0, write ignored, still OKAY.
//  Map: 0x00 CTRL RW [0]wd_en [1]cnt_clr (W1, self-clears, reads 0); 0x04 MAXCYCLE RW; 0x08 CYCLE RO;
//   0x0C STATUS RO [0]done [1]pass [2]fail [3]timeout [15:8]ch_exited mask; 0x10+4*ch EXIT[ch] WO.
//  Counter: increments every cycle in RUN; saturates at all-ones; cnt_clr zeroes it (clear wins over increment).
//  FSM RUN -> FAIL: EXIT[ch] write with nonzero data; exit_value_o = that code.
//  RUN -> PASS: last unexited channel written with 0 and no failure; exit_value_o = 0.
//  RUN -> TIMEOUT: wd_en & MAXCYCLE!=0 & cycle_cnt>=MAXCYCLE.
//  PASS/FAIL/TIMEOUT sticky until HRESET; outputs are registered, asserted the cycle after the causing event.
//  Each channel latches only its first exit write; repeat writes ignored. All writes to EXIT ignored once done.
//  Simultaneous exit-completion and watchdog expiry in one cycle: exit wins (PASS/FAIL, not TIMEOUT).
//  MAXCYCLE written below current count while wd_en: TIMEOUT next cycle. Counter freezes outside RUN.
//  HRESET mid-transfer: pending data phase discarded; no register update.
// STRUCTURE
//  ahb_test_ctrl_pkg: register offset localparams, STATUS bit indices, typedef enum {RUN,PASS,FAIL,TIMEOUT},
//   HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, TIMEOUT_TAG=16'hDEAD.
//  Sub-module ahb_lite_reg_if: address-phase capture, wr_en/rd_en/reg_idx/wdata strobes, HRDATA register.
//  Top holds counter, channel exit regs, FSM, output registers.
// TESTING
//  NUM_CH=2; write EXIT0=0, EXIT1=0 -> tests_passed_o=1 one cycle after 2nd write, exit_value_o=0, STATUS=0x0303.
//  Write EXIT1=0x2A -> tests_failed_o=1, exit_value_o=0x2A; later EXIT0=0 ignored, pass stays 0.
//  MAXCYCLE=100, no exits -> timeout_o=1 when CYCLE reaches 100; exit_value_o=0xDEAD0000; CYCLE frozen.
//  wd_en=0, MAXCYCLE=5, run 1000 cycles -> no timeout; CYCLE reads >=1000; then EXIT0/1=0 -> pass.
//  Last exit write in same cycle count hits MAXCYCLE -> PASS, timeout_o stays 0.
//  Back-to-back NONSEQ write then read of MAXCYCLE (0x1234) -> read returns 0x1234; HRESET mid-write -> MAXCYCLE=default.

Source files
------------

// File: rtl/ahb_test_ctrl_pkg.sv
// rtl/ahb_test_ctrl_pkg.sv - shared constants and types for the AHB test controller
package ahb_test_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int OFF_CTRL     = 'h00;
  localparam int OFF_MAXCYCLE = 'h04;
  localparam int OFF_CYCLE    = 'h08;
  localparam int OFF_STATUS   = 'h0C;
  localparam int OFF_EXIT0    = 'h10;

  localparam int CTRL_WD_EN   = 0;
  localparam int CTRL_CNT_CLR = 1;

  localparam int STAT_DONE       = 0;
  localparam int STAT_PASS       = 1;
  localparam int STAT_FAIL       = 2;
  localparam int STAT_TIMEOUT    = 3;
  localparam int STAT_EXITED_LSB = 8;

  localparam logic [15:0] TIMEOUT_TAG = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

endpackage

// File: rtl/ahb_lite_reg_if.sv
// rtl/ahb_lite_reg_if.sv - AHB-Lite address-phase capture, register strobes and HRDATA register
module ahb_lite_reg_if
  import ahb_test_ctrl_pkg::*;
#(
  parameter int ADDR_LSBS = 6
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          rd_data_i,
  output logic [31:0]          HRDATA,
  output logic [ADDR_LSBS-3:0] rd_idx_o,
  output logic                 wr_en_o,
  output logic [ADDR_LSBS-3:0] wr_idx_o,
  output logic [31:0]          wdata_o
);

  logic                 trans_active;
  logic                 addr_ok;
  logic                 dp_valid_d, dp_valid_q;
  logic                 dp_write_d, dp_write_q;
  logic [ADDR_LSBS-3:0] dp_idx_d, dp_idx_q;
  logic [31:0]          hrdata_d, hrdata_q;

  logic unused_haddr;
  assign unused_haddr = ^{HADDR[31:ADDR_LSBS], HADDR[1:0]};

  always_comb begin
    trans_active = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default: trans_active = 1'b0;
    endcase
    addr_ok    = HSEL & trans_active & HREADY;
    dp_valid_d = addr_ok;
    dp_write_d = addr_ok & HWRITE;
    dp_idx_d   = HADDR[ADDR_LSBS-1:2];
    // Read data is sampled at the address phase so it is stable for the whole data phase.
    hrdata_d   = (addr_ok & ~HWRITE) ? rd_data_i : '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      hrdata_q   <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      hrdata_q   <= hrdata_d;
    end
  end

  assign rd_idx_o = HADDR[ADDR_LSBS-1:2];
  assign wr_en_o  = dp_valid_q & dp_write_q;
  assign wr_idx_o = dp_idx_q;
  assign wdata_o  = HWDATA;
  assign HRDATA   = hrdata_q;

endmodule

// File: rtl/ahb_test_ctrl.sv
// rtl/ahb_test_ctrl.sv - AHB-Lite test controller: exit channels, cycle watchdog, sticky verdict
module ahb_test_ctrl
  import ahb_test_ctrl_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] DEF_MAXCYCLE = 32'd10_000_000,
  parameter int          ADDR_LSBS    = 6
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        timeout_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int IDX_W = ADDR_LSBS - 2;
  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(OFF_CTRL / 4);
  localparam logic [IDX_W-1:0] IDX_MAXCYCLE = IDX_W'(OFF_MAXCYCLE / 4);
  localparam logic [IDX_W-1:0] IDX_CYCLE    = IDX_W'(OFF_CYCLE / 4);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(OFF_STATUS / 4);
  localparam int               IDX_EXIT0    = OFF_EXIT0 / 4;

  logic [IDX_W-1:0]     rd_idx, wr_idx;
  logic                 wr_en;
  logic [31:0]          wdata, rd_data;

  state_e               state_d, state_q;
  logic [CNT_WIDTH-1:0] cycle_d, cycle_q;
  logic [CNT_WIDTH-1:0] maxcycle_d, maxcycle_q;
  logic                 wd_en_d, wd_en_q;
  logic [NUM_CH-1:0]    exited_d, exited_q;
  logic [31:0]          exit_value_d, exit_value_q;
  logic                 passed_d, passed_q, failed_d, failed_q;
  logic                 timeout_d, timeout_q, valid_d, valid_q;
  logic                 cnt_clr, exit_hit, exit_fail;

  ahb_lite_reg_if #(.ADDR_LSBS(ADDR_LSBS)) u_reg_if (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .rd_data_i (rd_data),
    .HRDATA    (HRDATA),
    .rd_idx_o  (rd_idx),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wdata_o   (wdata)
  );

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    maxcycle_d   = maxcycle_q;
    wd_en_d      = wd_en_q;
    exited_d     = exited_q;
    exit_value_d = exit_value_q;
    cnt_clr      = 1'b0;
    exit_hit     = 1'b0;
    exit_fail    = 1'b0;

    if (wr_en && wr_idx == IDX_CTRL) begin
      wd_en_d = wdata[CTRL_WD_EN];
      cnt_clr = wdata[CTRL_CNT_CLR];
    end
    if (wr_en && wr_idx == IDX_MAXCYCLE) maxcycle_d = wdata[CNT_WIDTH-1:0];

    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_en && state_q == ST_RUN && wr_idx == IDX_W'(IDX_EXIT0 + ch) && !exited_q[ch]) begin
        exited_d[ch] = 1'b1;
        exit_hit     = 1'b1;
        if (wdata != '0) begin
          exit_fail    = 1'b1;
          exit_value_d = wdata;
        end
      end
    end

    // Exit completion takes priority over a watchdog expiry in the same cycle.
    if (state_q == ST_RUN) begin
      if (exit_fail) begin
        state_d = ST_FAIL;
      end else if (exit_hit && (&exited_d)) begin
        state_d      = ST_PASS;
        exit_value_d = '0;
      end else if (wd_en_q && maxcycle_q != '0 && cycle_q >= maxcycle_q) begin
        state_d      = ST_TIMEOUT;
        exit_value_d = {TIMEOUT_TAG, 16'(exited_d)};
      end
    end

    if (cnt_clr) begin
      cycle_d = '0;
    end else if (state_d == ST_RUN && cycle_q != {CNT_WIDTH{1'b1}}) begin
      cycle_d = cycle_q + CNT_WIDTH'(1);
    end

    passed_d  = (state_d == ST_PASS);
    failed_d  = (state_d == ST_FAIL);
    timeout_d = (state_d == ST_TIMEOUT);
    valid_d   = (state_d != ST_RUN);

    // Reads see next-state values so a write in the preceding data phase is visible.
    rd_data = '0;
    if (rd_idx == IDX_CTRL) begin
      rd_data[CTRL_WD_EN] = wd_en_d;
    end else if (rd_idx == IDX_MAXCYCLE) begin
      rd_data = 32'(maxcycle_d);
    end else if (rd_idx == IDX_CYCLE) begin
      rd_data = 32'(cycle_d);
    end else if (rd_idx == IDX_STATUS) begin
      rd_data[STAT_DONE]              = valid_d;
      rd_data[STAT_PASS]              = passed_d;
      rd_data[STAT_FAIL]              = failed_d;
      rd_data[STAT_TIMEOUT]           = timeout_d;
      rd_data[STAT_EXITED_LSB +: 8]   = 8'(exited_d);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_RUN;
      cycle_q      <= '0;
      maxcycle_q   <= CNT_WIDTH'(DEF_MAXCYCLE);
      wd_en_q      <= 1'b1;
      exited_q     <= '0;
      exit_value_q <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      maxcycle_q   <= maxcycle_d;
      wd_en_q      <= wd_en_d;
      exited_q     <= exited_d;
      exit_value_q <= exit_value_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
    end
  end

  assign HREADYOUT      = 1'b1;
  assign HRESP          = 1'b0;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign timeout_o      = timeout_q;
  assign exit_valid_o   = valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_ahb_test_ctrl.sv
// tb/tb_ahb_test_ctrl.sv - directed table-driven bench for ahb_test_ctrl
module tb_ahb_test_ctrl;
  import ahb_test_ctrl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP;
  logic        tests_passed_o, tests_failed_o, timeout_o, exit_valid_o;
  logic [31:0] exit_value_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_MAXC = 32'h04, A_CYCLE = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C, A_EXIT0 = 32'h10, A_EXIT1 = 32'h14;
  localparam logic [31:0] DEF_MAX = 32'd10_000_000;

  ahb_test_ctrl dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HSEL           (HSEL),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HWRITE         (HWRITE),
    .HWDATA         (HWDATA),
    .HREADY         (HREADY),
    .HRDATA         (HRDATA),
    .HREADYOUT      (HREADYOUT),
    .HRESP          (HRESP),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .timeout_o      (timeout_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 HCLK = ~HCLK;

  typedef enum logic [1:0] {K_RST, K_WR, K_RD, K_OUT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(kind_e k, logic [31:0] a, logic [31:0] d,
                              logic [31:0] e, logic [3:0] f);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e; v.flags = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, exit_valid_o, tests_passed_o, tests_failed_o, timeout_o};
  endfunction

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    idle_bus();
    d = HRDATA;
  endtask

  logic [31:0] rd;

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HWDATA = '0;
    idle_bus();

    // Scenario A: reset state then both channels pass; scenario B: channel 1 fails.
    tbl.push_back(mk(K_RST, 0, 0, 0, 0));
    tbl.push_back(mk(K_OUT, 0, 0, 32'h0, 4'b0000));
    tbl.push_back(mk(K_RD, A_CTRL, 0, 32'h1, 0));
    tbl.push_back(mk(K_RD, A_MAXC, 0, DEF_MAX, 0));
    tbl.push_back(mk(K_RD, A_STAT, 0, 32'h0, 0));
    tbl.push_back(mk(K_RD, 32'h3C, 0, 32'h0, 0));
    tbl.push_back(mk(K_WR, A_EXIT0, 32'h0, 0, 0));
    tbl.push_back(mk(K_OUT, 0, 0, 32'h0, 4'b0000));
    tbl.push_back(mk(K_RD, A_STAT, 0, 32'h0100, 0));
    tbl.push_back(mk(K_WR, A_EXIT1, 32'h0, 0, 0));
    tbl.push_back(mk(K_OUT, 0, 0, 32'h0, 4'b1100));
    tbl.push_back(mk(K_RD, A_STAT, 0, 32'h0303, 0));
    tbl.push_back(mk(K_RST, 0, 0, 0, 0));
    tbl.push_back(mk(K_WR, A_EXIT1, 32'h2A, 0, 0));
    tbl.push_back(mk(K_OUT, 0, 0, 32'h2A, 4'b1010));
    tbl.push_back(mk(K_WR, A_EXIT0, 32'h0, 0, 0));
    tbl.push_back(mk(K_OUT, 0, 0, 32'h2A, 4'b1010));
    tbl.push_back(mk(K_RD, A_STAT, 0, 32'h0205, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].kind)
        K_RST: do_reset();
        K_WR:  ahb_write(tbl[i].addr, tbl[i].data);
        K_RD: begin
          ahb_read(tbl[i].addr, rd);
          chk($sformatf("vec%0d_read_%02h", i, tbl[i].addr[7:0]), rd, tbl[i].exp);
        end
        default: begin
          chk($sformatf("vec%0d_flags", i), flags_now(), {28'd0, tbl[i].flags});
          chk($sformatf("vec%0d_exit_value", i), exit_value_o, tbl[i].exp);
          chk($sformatf("vec%0d_hreadyout_hresp", i), {30'd0, HREADYOUT, HRESP}, 32'h2);
        end
      endcase
    end

    // Watchdog: MAXCYCLE=100 with no exits.
    do_reset();
    ahb_write(A_MAXC, 32'd100);
    chk("wd_no_early_timeout", {31'd0, timeout_o}, 32'd0);
    for (int i = 0; i < 300 && !timeout_o; i++) begin
      @(posedge HCLK); #1;
    end
    chk("wd_timeout_fired", flags_now(), 32'h9);
    chk("wd_exit_value", exit_value_o, 32'hDEAD_0000);
    ahb_read(A_CYCLE, rd);
    chk("wd_cycle_at_limit", rd, 32'd100);
    repeat (10) @(posedge HCLK);
    #1 ahb_read(A_CYCLE, rd);
    chk("wd_cycle_frozen", rd, 32'd100);
    ahb_read(A_STAT, rd);
    chk("wd_status", rd, 32'h0009);

    // MAXCYCLE lowered under the running count fires the cycle after the write lands.
    do_reset();
    repeat (20) @(posedge HCLK);
    #1 ahb_write(A_MAXC, 32'd3);
    chk("lower_max_not_yet", {31'd0, timeout_o}, 32'd0);
    @(posedge HCLK); #1;
    chk("lower_max_timeout", {31'd0, timeout_o}, 32'd1);

    // Watchdog disabled: long run, counter clear, then pass.
    do_reset();
    ahb_write(A_CTRL, 32'h0);
    ahb_write(A_MAXC, 32'd5);
    repeat (1000) @(posedge HCLK);
    #1 chk("wd_off_no_timeout", {31'd0, timeout_o}, 32'd0);
    ahb_read(A_CYCLE, rd);
    chk("wd_off_cycle_ge_1000", {31'd0, rd >= 32'd1000}, 32'd1);
    ahb_write(A_CTRL, 32'h2);
    ahb_read(A_CYCLE, rd);
    chk("cnt_clr_cycle", rd, 32'd1);
    ahb_read(A_CTRL, rd);
    chk("ctrl_clr_reads_0", rd, 32'd0);
    ahb_write(A_EXIT0, 32'h0);
    ahb_write(A_EXIT1, 32'h0);
    chk("wd_off_pass", flags_now(), 32'hC);

    // Last exit lands the same cycle the count reaches MAXCYCLE: exit wins.
    do_reset();
    ahb_write(A_CTRL, 32'h0);
    ahb_write(A_MAXC, 32'd1);
    ahb_write(A_EXIT0, 32'h0);
    ahb_write(A_CTRL, 32'h3);
    ahb_write(A_EXIT1, 32'h0);
    chk("race_pass", flags_now(), 32'hC);
    chk("race_exit_value", exit_value_o, 32'h0);
    @(posedge HCLK); #1;
    chk("race_no_timeout_later", {31'd0, timeout_o}, 32'd0);

    // Back-to-back write then read of MAXCYCLE.
    do_reset();
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = A_MAXC;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_SEQ; HWRITE = 1'b0; HADDR = A_MAXC; HWDATA = 32'h1234;
    @(posedge HCLK); #1;
    idle_bus();
    chk("b2b_read_maxcycle", HRDATA, 32'h1234);

    // Reset during a write data phase discards the write.
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = A_MAXC;
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = 32'h5555; HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    ahb_read(A_MAXC, rd);
    chk("reset_mid_write_maxcycle", rd, DEF_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
